// File: rtl/sign_mag_sub_if.sv
// Handshake bundle for the bit-serial sign-magnitude subtractor.
// The slave modport is the subtractor side; the master modport is the
// producer/consumer side that feeds operands and drains results.
interface sign_mag_sub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, overflow
  );
endinterface

// File: rtl/sign_mag_sub.sv
// Bit-serial sign-magnitude subtractor: diff = a - b.
// One magnitude bit is processed per clock, LSB first. When |a| < |b| in
// subtract mode the raw result is the two's complement of the wanted
// magnitude, so a second serial pass (FIX) negates it.
// Optional feature macro: SIGN_MAG_SUB_NEG_ZERO_CLR_EN forces the sign of a
// zero-magnitude result to 0 so -0 is never produced.
module sign_mag_sub #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  sign_mag_sub_if.slave   bus
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Operand magnitudes shift right so bit 0 is always the current bit.
  logic [M-1:0]  a_sh;
  logic [M-1:0]  b_sh;
  logic [M-1:0]  res;
  logic          a_sign;
  logic          esb;
  logic          sub_mode;
  logic          cb;         // carry (add mode) or borrow (sub mode)
  logic          seen_one;   // FIX: a 1 has already passed through
  logic [CW-1:0] cnt;

  logic [WIDTH-1:0] diff_q;
  logic             ovf_q;

  logic          accept;
  logic          last_bit;
  logic          r;
  logic          cb_nxt;
  logic          fix_bit;
  logic [M-1:0]  calc_mag;
  logic [M-1:0]  fix_mag;
  logic          calc_sign;
  logic          fix_sign;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = diff_q;
  assign bus.overflow  = ovf_q;

  assign accept   = bus.in_valid && (state == IDLE);
  assign last_bit = (cnt == CW'(M - 1));

  // Per-bit arithmetic, negation step and final sign selection.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    r         = a_sh[0] ^ b_sh[0] ^ cb;
    cb_nxt    = 1'b0;
    fix_bit   = seen_one ? ~res[0] : res[0];
    calc_mag  = {r, res[M-1:1]};
    fix_mag   = {fix_bit, res[M-1:1]};
    calc_sign = a_sign;
    fix_sign  = esb;
    if (sub_mode) begin
      cb_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & cb);
    end else begin
      cb_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & cb) | (b_sh[0] & cb);
    end
`ifdef SIGN_MAG_SUB_NEG_ZERO_CLR_EN
    calc_sign = a_sign & (|calc_mag);
    fix_sign  = esb & (|fix_mag);
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (last_bit) state_nxt = (sub_mode && cb_nxt) ? FIX : DONE;
      FIX:  if (last_bit) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, serial add/sub, serial negation, result load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      a_sign   <= 1'b0;
      esb      <= 1'b0;
      sub_mode <= 1'b0;
      cb       <= 1'b0;
      seen_one <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_sh     <= bus.a[M-1:0];
            b_sh     <= bus.b[M-1:0];
            a_sign   <= bus.a[WIDTH-1];
            esb      <= ~bus.b[WIDTH-1];
            sub_mode <= (bus.a[WIDTH-1] != ~bus.b[WIDTH-1]);
            res      <= '0;
            cb       <= 1'b0;
            seen_one <= 1'b0;
            cnt      <= '0;
          end
        end
        CALC: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= calc_mag;
          cb   <= cb_nxt;
          if (last_bit) begin
            cnt <= '0;
            // Borrow-out means the register holds |b|-|a| in two's
            // complement; the output waits until FIX has negated it.
            if (!(sub_mode && cb_nxt)) begin
              diff_q <= {calc_sign, calc_mag};
              ovf_q  <= sub_mode ? 1'b0 : cb_nxt;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIX: begin
          res      <= fix_mag;
          seen_one <= seen_one | res[0];
          if (last_bit) begin
            cnt    <= '0;
            diff_q <= {fix_sign, fix_mag};
            ovf_q  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          // Outputs held; nothing to update.
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sign_mag_sub.sv
// Self-checking bench for sign_mag_sub at WIDTH=8.
// Expected results come from an arithmetic model of signed subtraction and
// are queued when operands are driven, then popped when out_valid rises.
module tb_sign_mag_sub;

  localparam int WIDTH = 8;
  localparam int M     = WIDTH - 1;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             ovf;
    int               lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb[$];

  sign_mag_sub_if #(.WIDTH(WIDTH)) bus ();

  sign_mag_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int   ma;
    int   mb;
    int   mag;
    logic s;
    logic esb;
    ma    = int'(a[M-1:0]);
    mb    = int'(b[M-1:0]);
    esb   = ~b[WIDTH-1];
    e.ovf = 1'b0;
    e.lat = M;
    if (a[WIDTH-1] == esb) begin
      mag   = ma + mb;
      e.ovf = (mag >= (1 << M));
      mag   = mag % (1 << M);
      s     = a[WIDTH-1];
    end else if (ma >= mb) begin
      mag = ma - mb;
      s   = a[WIDTH-1];
    end else begin
      mag   = mb - ma;
      s     = esb;
      e.lat = 2 * M;
    end
`ifdef SIGN_MAG_SUB_NEG_ZERO_CLR_EN
    if (mag == 0) s = 1'b0;
`endif
    e.diff = {s, M'(mag)};
    return e;
  endfunction

  // Drive one operation (called at a negedge), wait for the result, compare
  // against the scoreboard head and release it with out_ready.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int   lat;
    check({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    sb.push_back(model(a, b));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, ".latency"}, 32'(lat), 32'(e.lat));
      check({tag, ".diff"}, 32'(bus.diff), 32'(e.diff));
      check({tag, ".overflow"}, 32'(bus.overflow), 32'(e.ovf));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, ".released"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   lat;
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check("rst.diff", 32'(bus.diff), 32'd0);
    check("rst.overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("p5_m_p3", 8'h05, 8'h03);
    do_op("p3_m_p5", 8'h03, 8'h05);
    do_op("p5_m_n3", 8'h05, 8'h83);
    do_op("p127_m_n1", 8'h7F, 8'h81);
    do_op("n5_m_n5", 8'h85, 8'h85);
    do_op("n3_m_p5", 8'h83, 8'h05);
    do_op("n3_m_n5", 8'h83, 8'h85);
    do_op("n64_m_p64", 8'hC0, 8'h40);
    do_op("p0_m_p1", 8'h00, 8'h01);

    // Backpressure: hold DONE for 5 cycles while in_valid is pulsed.
    check("bp.in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = 8'h10;
    bus.b        = 8'h01;
    sb.push_back(model(8'h10, 8'h01));
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check("bp.latency", 32'(lat), 32'(e.lat));
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 1) || (i == 2);
      bus.a        = 8'h22;
      bus.b        = 8'h11;
      check("bp.hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp.hold_diff", 32'(bus.diff), 32'(e.diff));
      check("bp.hold_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp.release_valid", 32'(bus.out_valid), 32'd0);
    check("bp.release_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp.diff_kept", 32'(bus.diff), 32'h0F);
    do_op("after_bp", 8'h09, 8'h02);

    // Reset in the middle of a borrow-path operation.
    bus.in_valid = 1'b1;
    bus.a        = 8'h03;
    bus.b        = 8'h05;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst.in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst.diff", 32'(bus.diff), 32'd0);
    check("mid_rst.overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) lat++;
      @(negedge clk);
    end
    check("mid_rst.no_result", 32'(lat), 32'd0);
    do_op("after_rst", 8'h7F, 8'h01);
    do_op("after_rst2", 8'h01, 8'h7F);

    check("sb.drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sign_mag_sub.md
# sign_mag_sub

Bit-serial sign-magnitude subtractor computing `diff = a - b` on WIDTH-bit sign-magnitude operands (MSB = sign, low WIDTH-1 bits = magnitude). It is the subtracting counterpart to the team's combinational sign-magnitude adder. It trades area for latency: one magnitude bit per clock, with a valid/ready handshake on both sides. It sits in datapaths where operands arrive sporadically and a full-width comparator plus subtractor is not justified.

## Interface
- `WIDTH`, default 8: total operand/result width, including the sign bit. Must be ≥ 3. M = WIDTH-1 is the magnitude width.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: operands `a`, `b` are valid.
- `in_ready`, output, 1: block can accept operands. High only in IDLE.
- `a`, input, WIDTH: minuend, sign-magnitude.
- `b`, input, WIDTH: subtrahend, sign-magnitude.
- `out_valid`, output, 1: `diff`/`overflow` valid. High only in DONE.
- `out_ready`, input, 1: consumer accepts the result.
- `diff`, output, WIDTH: result, sign-magnitude.
- `overflow`, output, 1: magnitude carry-out occurred. Only possible in add mode.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Reset values: state IDLE, `out_valid`=0, `diff`=0, `overflow`=0, `in_ready`=1, all internal registers 0.
- **IDLE**
  - `in_valid & in_ready` latches `a` and `b`.
  - Effective subtrahend sign: `esb = ~b[WIDTH-1]`.
  - Mode: add if `a[WIDTH-1] == esb`, otherwise sub.
  - Clear carry/borrow and the bit counter, then go to CALC.
- **CALC**, exactly M cycles, LSB first, bit i per cycle:
  - Add mode: `r = a_i ^ b_i ^ c`; `c' = majority(a_i, b_i, c)`.
  - Sub mode: `r = a_i ^ b_i ^ br`; `br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)`.
  - `r` shifts into the result register from the MSB end (right shift). After M cycles the register holds the magnitude.
- **End of CALC**
  - Add mode: sign = `a[WIDTH-1]`; `overflow` = final carry; magnitude = low M bits (wrapped). Go to DONE.
  - Sub mode, final borrow 0 (|a| ≥ |b|): sign = `a[WIDTH-1]`; `overflow`=0. Go to DONE.
  - Sub mode, final borrow 1 (|a| < |b|): sign = `esb`; `overflow`=0. Go to FIX.
- **FIX**, exactly M cycles: serial two's-complement negation of the result register, LSB first. Bits pass unchanged up to and including the first 1; later bits are inverted. Then go to DONE.
- **DONE**
  - `out_valid`=1; `diff` and `overflow` are held stable.
  - On `out_ready`: go to IDLE and drop `out_valid` on the same edge. `diff` and `overflow` keep their last values until the next DONE.
- Equal magnitudes in sub mode: magnitude 0, sign = `a[WIDTH-1]`. See Configuration.
- `in_valid` is ignored outside IDLE. Operands are not re-sampled mid-operation.

## Timing
- Accept edge: the edge where `in_valid & in_ready` is high in IDLE.
- Latency from accept edge to `out_valid` high:
  - M cycles for add mode, or sub mode without borrow.
  - 2M cycles for sub mode with borrow.
- `in_ready` is combinational from state: 1 in IDLE, 0 in all other states.
- Throughput with `out_ready` tied high: one result per M+2 cycles (no borrow) or 2M+2 cycles (borrow).
- Backpressure: DONE persists indefinitely with outputs constant.
- Asynchronous reset asserted in any state: immediate return to IDLE with the reset values above. The in-flight operation is discarded and no result is produced.

## Configuration
- Macro: `SIGN_MAG_SUB_NEG_ZERO_CLR_EN`.
- Defined: when the final magnitude is 0 (exact cancellation, or add-mode wrap to 0), the sign is forced to 0, so `-0` is never output.
- Undefined: the sign follows the rules above, so `-0` (e.g. 0x80 at WIDTH=8) can appear.

## Test plan
All at WIDTH=8, M=7.
- a=0x05, b=0x03 (+5 − +3) → `diff`=0x02, `overflow`=0, `out_valid` 7 cycles after accept.
- a=0x03, b=0x05 (+3 − +5) → borrow path → `diff`=0x82, `overflow`=0, `out_valid` 14 cycles after accept.
- a=0x05, b=0x83 (+5 − −3) → `diff`=0x08. Then a=0x7F, b=0x81 (+127 − −1) → `diff`=0x00, `overflow`=1.
- a=0x85, b=0x85 (−5 − −5) → `diff`=0x80 without the macro, 0x00 with `SIGN_MAG_SUB_NEG_ZERO_CLR_EN`.
- a=0x10, b=0x01 with `out_ready` low for 5 cycles in DONE and `in_valid` pulsed meanwhile → `diff`=0x0F held constant, `in_ready`=0, second operand ignored. Release `out_ready` → IDLE next cycle.
- `rst_n` pulsed low 3 cycles after accepting a=0x03, b=0x05 → outputs return to reset values immediately, no `out_valid`. A new operation afterwards completes correctly.
